// File: rtl/mux4to1.sv
// 4-to-1 multiplexer with a combinational output and an enabled
// registered copy. The registered copy carries the select it was captured
// with, a flag saying a capture has happened since reset, and a one-cycle
// pulse flagging a change of captured select.

// Runtime checker: structural invariants of the registered path.
module mux4to1_checker (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] S_q,
    input logic       valid_q,
    input logic       sel_chg
);

    // A select-change pulse can only follow an earlier capture.
    a_chg_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        sel_chg |-> valid_q);

    // Until the first capture, the captured select is still its reset value.
    a_idle_select: assert property (@(posedge clk) disable iff (!rst_n)
        !valid_q |-> (S_q == 2'b00));

endmodule

module mux4to1 #(
    parameter int unsigned     SIZE      = 4,
    parameter logic [SIZE-1:0] RESET_VAL = {SIZE{1'b0}}
) (
    output logic [SIZE-1:0] Y,
    input  logic [SIZE-1:0] I0,
    input  logic [SIZE-1:0] I1,
    input  logic [SIZE-1:0] I2,
    input  logic [SIZE-1:0] I3,
    input  logic [1:0]      S,
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [SIZE-1:0] Y_q,
    output logic [1:0]      S_q,
    output logic            valid_q,
    output logic            sel_chg
);

    logic [SIZE-1:0] y_s;
    logic            sel_chg_nxt_s;
    logic [SIZE-1:0] y_q_r;
    logic [1:0]      s_q_r;
    logic            valid_q_r;
    logic            sel_chg_r;

    // Select decode; an unknown select propagates as all-X in simulation
    // and is a don't-care for synthesis.
    always_comb begin
        y_s = {SIZE{1'bx}};
        case (S)
            2'b00:   y_s = I0;
            2'b01:   y_s = I1;
            2'b10:   y_s = I2;
            2'b11:   y_s = I3;
            default: y_s = {SIZE{1'bx}};
        endcase
    end

    assign Y = y_s;

    // A change is only meaningful against a select that was really
    // captured, so the very first capture after reset never pulses.
    always_comb begin
        sel_chg_nxt_s = 1'b0;
        if (en && valid_q_r && (S != s_q_r)) begin
            sel_chg_nxt_s = 1'b1;
        end else begin
            sel_chg_nxt_s = 1'b0;
        end
    end

    // Capture register: load mux output and select on enable, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_r     <= RESET_VAL;
            s_q_r     <= 2'b00;
            valid_q_r <= 1'b0;
        end else if (en) begin
            y_q_r     <= y_s;
            s_q_r     <= S;
            valid_q_r <= 1'b1;
        end else begin
            y_q_r     <= y_q_r;
            s_q_r     <= s_q_r;
            valid_q_r <= valid_q_r;
        end
    end

    // Select-change pulse register; reset kills a pending pulse at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_chg_r <= 1'b0;
        end else begin
            sel_chg_r <= sel_chg_nxt_s;
        end
    end

    assign Y_q     = y_q_r;
    assign S_q     = s_q_r;
    assign valid_q = valid_q_r;
    assign sel_chg = sel_chg_r;

    mux4to1_checker u_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .S_q     (s_q_r),
        .valid_q (valid_q_r),
        .sel_chg (sel_chg_r)
    );

endmodule

// File: tb/tb_mux4to1.sv
// Self-checking bench for mux4to1: directed scenarios followed by a
// randomized run against a transaction-level reference model.
`timescale 1ns/1ps

module tb_mux4to1;

    logic [3:0] Y;
    logic [3:0] I0;
    logic [3:0] I1;
    logic [3:0] I2;
    logic [3:0] I3;
    logic [1:0] S;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] Y_q;
    logic [1:0] S_q;
    logic       valid_q;
    logic       sel_chg;

    int n_cmp;
    int n_bad;

    // Reference model state for the registered path.
    logic [3:0] m_yq;
    logic [1:0] m_sq;
    logic       m_valid;
    logic       m_chg;

    mux4to1 #(.SIZE(4), .RESET_VAL(4'b0000)) dut (
        .Y       (Y),
        .I0      (I0),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .S       (S),
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .Y_q     (Y_q),
        .S_q     (S_q),
        .valid_q (valid_q),
        .sel_chg (sel_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference selection: the input numbered by the select value.
    function automatic logic [3:0] pick(input logic [1:0] sel);
        logic [3:0] ins [4];
        ins[0] = I0;
        ins[1] = I1;
        ins[2] = I2;
        ins[3] = I3;
        return ins[sel];
    endfunction

    task automatic test_static_select();
        logic [3:0] want;
        I0 = 4'b0000; I1 = 4'b0001; I2 = 4'b0010; I3 = 4'b0011;
        for (int s = 0; s < 4; s++) begin
            S = 2'(s);
            #100;
            want = 4'(s);
            n_cmp++;
            if (Y !== want) begin
                n_bad++;
                $display("FAIL static_y s=%0d: got %b want %b", s, Y, want);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            I0 = 4'($urandom); I1 = 4'($urandom);
            I2 = 4'($urandom); I3 = 4'($urandom);
            S  = 2'($urandom_range(0, 3));
            en = 1'($urandom);
            #1;
            n_cmp++;
            if (Y !== pick(S)) begin
                n_bad++; $display("FAIL rst_y: got %b want %b", Y, pick(S));
            end
            @(posedge clk); #1;
            n_cmp++;
            if (Y_q !== 4'b0000) begin
                n_bad++; $display("FAIL rst_yq: got %b want %b", Y_q, 4'b0000);
            end
            n_cmp++;
            if (S_q !== 2'b00) begin
                n_bad++; $display("FAIL rst_sq: got %b want %b", S_q, 2'b00);
            end
            n_cmp++;
            if (valid_q !== 1'b0) begin
                n_bad++; $display("FAIL rst_valid: got %b want %b", valid_q, 1'b0);
            end
            n_cmp++;
            if (sel_chg !== 1'b0) begin
                n_bad++; $display("FAIL rst_chg: got %b want %b", sel_chg, 1'b0);
            end
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1; S = 2'b10; I2 = 4'b0010;
        @(posedge clk); #1;
        n_cmp++;
        if (Y_q !== 4'b0010) begin
            n_bad++; $display("FAIL cap_yq: got %b want %b", Y_q, 4'b0010);
        end
        n_cmp++;
        if (S_q !== 2'b10) begin
            n_bad++; $display("FAIL cap_sq: got %b want %b", S_q, 2'b10);
        end
        n_cmp++;
        if (valid_q !== 1'b1) begin
            n_bad++; $display("FAIL cap_valid: got %b want %b", valid_q, 1'b1);
        end
        n_cmp++;
        if (sel_chg !== 1'b0) begin
            n_bad++; $display("FAIL cap_chg: got %b want %b", sel_chg, 1'b0);
        end
    endtask

    task automatic test_select_change();
        @(negedge clk);
        S = 2'b11; I3 = 4'b0011; en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (Y_q !== 4'b0011) begin
            n_bad++; $display("FAIL chg_yq: got %b want %b", Y_q, 4'b0011);
        end
        n_cmp++;
        if (sel_chg !== 1'b1) begin
            n_bad++; $display("FAIL chg_pulse: got %b want %b", sel_chg, 1'b1);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (sel_chg !== 1'b0) begin
            n_bad++; $display("FAIL chg_hold0: got %b want %b", sel_chg, 1'b0);
        end
        n_cmp++;
        if (S_q !== 2'b11) begin
            n_bad++; $display("FAIL chg_sq: got %b want %b", S_q, 2'b11);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b0; S = 2'b00; I0 = 4'b0000;
        #1;
        n_cmp++;
        if (Y !== 4'b0000) begin
            n_bad++; $display("FAIL hold_y: got %b want %b", Y, 4'b0000);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (Y_q !== 4'b0011) begin
            n_bad++; $display("FAIL hold_yq: got %b want %b", Y_q, 4'b0011);
        end
        n_cmp++;
        if (S_q !== 2'b11) begin
            n_bad++; $display("FAIL hold_sq: got %b want %b", S_q, 2'b11);
        end
        n_cmp++;
        if (sel_chg !== 1'b0) begin
            n_bad++; $display("FAIL hold_chg: got %b want %b", sel_chg, 1'b0);
        end
        n_cmp++;
        if (valid_q !== 1'b1) begin
            n_bad++; $display("FAIL hold_valid: got %b want %b", valid_q, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1; S = 2'b00; I0 = 4'b0101;
        @(posedge clk); #1;
        n_cmp++;
        if (sel_chg !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre_chg: got %b want %b", sel_chg, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sel_chg !== 1'b0) begin
            n_bad++; $display("FAIL arst_chg: got %b want %b", sel_chg, 1'b0);
        end
        n_cmp++;
        if (valid_q !== 1'b0) begin
            n_bad++; $display("FAIL arst_valid: got %b want %b", valid_q, 1'b0);
        end
        n_cmp++;
        if (Y_q !== 4'b0000) begin
            n_bad++; $display("FAIL arst_yq: got %b want %b", Y_q, 4'b0000);
        end
        n_cmp++;
        if (Y !== 4'b0101) begin
            n_bad++; $display("FAIL arst_y: got %b want %b", Y, 4'b0101);
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [6];
        logic       want_chg [6];
        logic [3:0] want_yq;
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
        seq[3] = 2'b00; seq[4] = 2'b00; seq[5] = 2'b00;
        want_chg[0] = 1'b0; want_chg[1] = 1'b1; want_chg[2] = 1'b1;
        want_chg[3] = 1'b1; want_chg[4] = 1'b0; want_chg[5] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            en = 1'b1; S = seq[k];
            I0 = 4'($urandom); I1 = 4'($urandom);
            I2 = 4'($urandom); I3 = 4'($urandom);
            want_yq = pick(seq[k]);
            @(posedge clk); #1;
            n_cmp++;
            if (sel_chg !== want_chg[k]) begin
                n_bad++;
                $display("FAIL b2b_chg k=%0d: got %b want %b", k, sel_chg, want_chg[k]);
            end
            n_cmp++;
            if (Y_q !== want_yq) begin
                n_bad++;
                $display("FAIL b2b_yq k=%0d: got %b want %b", k, Y_q, want_yq);
            end
        end
    endtask

    task automatic test_random();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_yq = 4'b0000; m_sq = 2'b00; m_valid = 1'b0; m_chg = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            I0 = 4'($urandom); I1 = 4'($urandom);
            I2 = 4'($urandom); I3 = 4'($urandom);
            if ($urandom_range(0, 1) == 0) S = m_sq;
            else S = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (Y !== pick(S)) begin
                n_bad++; $display("FAIL rnd_y k=%0d: got %b want %b", k, Y, pick(S));
            end
            // Transaction-level prediction of the coming edge.
            if (en) begin
                m_chg   = m_valid && (S != m_sq);
                m_yq    = pick(S);
                m_sq    = S;
                m_valid = 1'b1;
            end else begin
                m_chg   = 1'b0;
            end
            @(posedge clk); #1;
            n_cmp++;
            if (Y_q !== m_yq) begin
                n_bad++; $display("FAIL rnd_yq k=%0d: got %b want %b", k, Y_q, m_yq);
            end
            n_cmp++;
            if (S_q !== m_sq) begin
                n_bad++; $display("FAIL rnd_sq k=%0d: got %b want %b", k, S_q, m_sq);
            end
            n_cmp++;
            if (valid_q !== m_valid) begin
                n_bad++; $display("FAIL rnd_valid k=%0d: got %b want %b", k, valid_q, m_valid);
            end
            n_cmp++;
            if (sel_chg !== m_chg) begin
                n_bad++; $display("FAIL rnd_chg k=%0d: got %b want %b", k, sel_chg, m_chg);
            end
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                m_yq = 4'b0000; m_sq = 2'b00; m_valid = 1'b0; m_chg = 1'b0;
                n_cmp++;
                if ({Y_q, S_q, valid_q, sel_chg} !== {m_yq, m_sq, m_valid, m_chg}) begin
                    n_bad++;
                    $display("FAIL rnd_arst k=%0d: got %b want %b", k,
                             {Y_q, S_q, valid_q, sel_chg}, {m_yq, m_sq, m_valid, m_chg});
                end
                rst_n = 1'b1;
            end
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        en = 1'b0;
        S = 2'b00;
        I0 = 4'b0000; I1 = 4'b0000; I2 = 4'b0000; I3 = 4'b0000;
        #2;
        rst_n = 1'b0;
        test_static_select();
        test_reset();
        test_capture();
        test_select_change();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
